// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // RISC-V load/store width codes (funct3)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal width code, or a halfword/word that is not naturally aligned.
  function automatic logic bad_access(input logic [2:0] f3, input logic [1:0] a_lo);
    logic illegal;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return illegal
        || ((f3[1:0] == LH[1:0]) && a_lo[0])
        || ((f3[1:0] == LW[1:0]) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory bus for the data-memory arbiter.
interface dmem_arb_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  // requester side (bit 0 = MEM stage, bit 1 = debug/loader)
  logic [1:0]                 req;
  logic [1:0]                 we;
  logic [1:0][DM_ADDRESS-1:0] addr;
  logic [1:0][DATA_W-1:0]     wdata;
  logic [1:0][2:0]            funct3;
  logic [1:0]                 gnt;
  logic [1:0]                 rvalid;
  logic [1:0]                 err;
  logic [DATA_W-1:0]          rdata;
  // memory side
  logic                       MemRead;
  logic                       MemWrite;
  logic [DM_ADDRESS-1:0]      a;
  logic [DATA_W-1:0]          wd;
  logic [2:0]                 Funct3;
  logic [DATA_W-1:0]          rd;

  // arbiter view
  modport slave (
    input  req, we, addr, wdata, funct3, rd,
    output gnt, rvalid, err, rdata, MemRead, MemWrite, a, wd, Funct3
  );

  // environment view: requesters plus the memory that returns rd
  modport master (
    output req, we, addr, wdata, funct3, rd,
    input  gnt, rvalid, err, rdata, MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: on a tie the port not served last wins.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // one-hot grant; a lone requester always wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE grants, ACCESS drives memory, RESP answers.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic     clk,
  input  logic     reset,
  dmem_arb_if.slave bus
);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;   // port served last; 1 at reset so port 0 is next
  logic                  we_q, we_d;
  logic                  flag_q, flag_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [2:0]            f3_q, f3_d;
  logic [NUM_PORTS-1:0]  pick;
  logic                  sel;

  dmem_rr_pick u_pick (
    .req   (bus.req),
    .last  (last_q),
    .grant (pick)
  );

  assign sel = pick[1];

  // state and latched request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      flag_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      flag_q  <= flag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
    end
  end

  // next-state, capture of the granted request, and response data
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    flag_d  = flag_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = ACCESS;
          owner_d = sel;
          last_d  = sel;
          we_d    = bus.we[sel];
          addr_d  = bus.addr[sel];
          wdata_d = bus.wdata[sel];
          f3_d    = bus.funct3[sel];
          flag_d  = bad_access(bus.funct3[sel], bus.addr[sel][1:0]);
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (!we_q && !flag_q) ? bus.rd : '0;
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // requester-side outputs; gnt is held off while reset is asserted
  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    bus.err    = '0;
    bus.rdata  = rdata_q;
    if (state_q == IDLE && !reset) bus.gnt = pick;
    if (state_q == RESP) begin
      bus.rvalid[owner_q] = 1'b1;
      bus.err[owner_q]    = flag_q;
    end
  end

  // memory-side outputs, live only during ACCESS
  always_comb begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.a        = '0;
    bus.wd       = '0;
    bus.Funct3   = '0;
    if (state_q == ACCESS) begin
      bus.a        = addr_q;
      bus.wd       = wdata_q;
      bus.Funct3   = f3_q;
      bus.MemRead  = !we_q && !flag_q;
      bus.MemWrite = we_q && !flag_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte memory and a shadow model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   nxt = 0;          // model: port that wins a tie

  bit [7:0] mem [512];    // memory attached to the arbiter
  bit [7:0] ref_mem [512];// model's view of memory contents

  dmem_arb_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // load result from four little-endian bytes
  function automatic logic [31:0] assemble(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  // memory read path is combinational from a / Funct3
  always_comb begin
    bus.rd = assemble(bus.Funct3, mem[bus.a], mem[bus.a + 9'd1], mem[bus.a + 9'd2], mem[bus.a + 9'd3]);
  end

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      mem[bus.a] <= bus.wd[7:0];
      if (bus.Funct3[1:0] != 2'b00) mem[bus.a + 9'd1] <= bus.wd[15:8];
      if (bus.Funct3[1:0] == 2'b10) begin
        mem[bus.a + 9'd2] <= bus.wd[23:16];
        mem[bus.a + 9'd3] <= bus.wd[31:24];
      end
    end
  end

  function automatic logic model_flag(input logic [2:0] f3, input logic [8:0] ad);
    int sz;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (ad % sz) != 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_mem(input string tag);
    check({tag, "_memrd"}, {31'd0, bus.MemRead}, 32'd0);
    check({tag, "_memwr"}, {31'd0, bus.MemWrite}, 32'd0);
    check({tag, "_a"}, {23'd0, bus.a}, 32'd0);
    check({tag, "_wd"}, bus.wd, 32'd0);
    check({tag, "_f3"}, {29'd0, bus.Funct3}, 32'd0);
  endtask

  // one transaction from a lone requester, checked cycle by cycle
  task automatic issue(input int p, input logic w, input logic [8:0] ad,
                       input logic [31:0] d, input logic [2:0] f3);
    logic        fl;
    logic [31:0] ex;
    logic [1:0]  oh;
    int          n;
    fl = model_flag(f3, ad);
    oh = (p == 0) ? 2'b01 : 2'b10;
    ex = 32'd0;
    if (!w && !fl)
      ex = assemble(f3, ref_mem[ad], ref_mem[ad + 9'd1], ref_mem[ad + 9'd2], ref_mem[ad + 9'd3]);
    @(negedge clk);
    bus.req[p] = 1'b1; bus.we[p] = w; bus.addr[p] = ad; bus.wdata[p] = d; bus.funct3[p] = f3;
    #1;
    n = 0;
    while (bus.gnt[p] !== 1'b1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("gnt", {30'd0, bus.gnt}, {30'd0, oh});
    if (n < 10) nxt = 1 - p;
    @(negedge clk);
    bus.req[p] = 1'b0;
    #1;
    check("acc_memrd", {31'd0, bus.MemRead}, {31'd0, !w && !fl});
    check("acc_memwr", {31'd0, bus.MemWrite}, {31'd0, w && !fl});
    check("acc_a", {23'd0, bus.a}, {23'd0, ad});
    check("acc_rvalid", {30'd0, bus.rvalid}, 32'd0);
    check("acc_gnt", {30'd0, bus.gnt}, 32'd0);
    @(negedge clk); #1;
    check("rsp_rvalid", {30'd0, bus.rvalid}, {30'd0, oh});
    check("rsp_err", {30'd0, bus.err}, {30'd0, fl ? oh : 2'b00});
    check("rsp_rdata", bus.rdata, ex);
    check_quiet_mem("rsp");
    if (w && !fl) begin
      ref_mem[ad] = d[7:0];
      if (f3[1:0] != 2'd0) ref_mem[ad + 9'd1] = d[15:8];
      if (f3[1:0] == 2'd2) begin
        ref_mem[ad + 9'd2] = d[23:16];
        ref_mem[ad + 9'd3] = d[31:24];
      end
    end
  endtask

  initial begin
    int          got;
    int          last_cyc;
    int          cyc;
    int          p;
    logic        w;
    logic [8:0]  ad;
    logic [2:0]  f3;
    logic [2:0]  st_codes [6];
    logic [2:0]  ld_codes [8];
    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.funct3 = '0;

    // reset state, including a pending request during reset
    #2;
    check("rst_gnt", {30'd0, bus.gnt}, 32'd0);
    check("rst_rvalid", {30'd0, bus.rvalid}, 32'd0);
    check("rst_err", {30'd0, bus.err}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check_quiet_mem("rst");
    bus.req = 2'b11; #1;
    check("rst_gnt_req", {30'd0, bus.gnt}, 32'd0);
    bus.req = 2'b00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    nxt = 0;

    // both requesting continuously: strict alternation from port 0, one grant per 3 cycles
    bus.we = 2'b00; bus.funct3 = '{3'd2, 3'd2};
    bus.addr[0] = 9'h020; bus.addr[1] = 9'h024;
    bus.req = 2'b11;
    got = 0; cyc = 0; last_cyc = -3;
    #1;
    while (got < 6 && cyc < 60) begin
      if (bus.gnt !== 2'b00) begin
        check("rr_gnt", {30'd0, bus.gnt}, (nxt == 0) ? 32'd1 : 32'd2);
        if (got > 0) check("rr_spacing", cyc - last_cyc, 32'd3);
        last_cyc = cyc;
        nxt = 1 - nxt;
        got++;
      end
      if (got < 6) begin
        @(negedge clk); #1; cyc++;
      end
    end
    check("rr_count", got, 32'd6);
    @(negedge clk); bus.req = 2'b00;
    @(negedge clk); @(negedge clk);

    // store then load back a word on port 0
    issue(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2);
    issue(0, 1'b0, 9'h010, 32'h0, 3'd2);
    check("sw_lw_data", {mem[9'h013], mem[9'h012], mem[9'h011], mem[9'h010]}, 32'hDEADBEEF);

    // misaligned halfword on port 1
    issue(1, 1'b0, 9'h003, 32'h0, 3'd1);

    // byte store, signed and unsigned byte loads
    issue(0, 1'b1, 9'h005, 32'h00000080, 3'd0);
    issue(1, 1'b0, 9'h005, 32'h0, 3'd0);
    issue(0, 1'b0, 9'h005, 32'h0, 3'd4);

    // reset during ACCESS of a port 1 load
    @(negedge clk);
    bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr[1] = 9'h010; bus.funct3[1] = 3'd2;
    #1;
    check("rstmid_gnt", {30'd0, bus.gnt}, 32'd2);
    @(negedge clk);
    bus.req[1] = 1'b0; #1;
    check("rstmid_acc", {31'd0, bus.MemRead}, 32'd1);
    reset = 1'b1; #1;
    check("rstmid_rvalid0", {30'd0, bus.rvalid}, 32'd0);
    check_quiet_mem("rstmid");
    @(negedge clk); #1;
    check("rstmid_rvalid1", {30'd0, bus.rvalid}, 32'd0);
    reset = 1'b0;
    nxt = 0;
    @(negedge clk); #1;
    check("rstmid_rvalid2", {30'd0, bus.rvalid}, 32'd0);
    check("rstmid_rdata", bus.rdata, 32'd0);
    bus.addr[0] = 9'h010; bus.funct3[0] = 3'd2; bus.we = 2'b00;
    bus.req = 2'b11; #1;
    check("rstmid_next", {30'd0, bus.gnt}, 32'd1);
    nxt = 1;
    @(negedge clk); bus.req = 2'b00;
    @(negedge clk); #1;
    check("rstmid_after", bus.rdata, 32'hDEADBEEF);

    // randomized single-requester traffic against the model
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      f3 = w ? st_codes[$urandom_range(0, 5)] : ld_codes[$urandom_range(0, 7)];
      ad = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) ad = ad & 9'h1FC;
      if ($urandom_range(0, 2) == 0) ad = 9'h040 + (ad & 9'h00F);
      issue(p, w, ad, $urandom, f3);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
